// File: rtl/cnu_pkg.sv
// Shared helpers for the CNU comparator-tree scheduler: width math,
// the idle fill bit and the result-entry width.
package cnu_pkg;

    // Every bit of an idle tree input is this value, so the whole vector is a neutral maximum.
    localparam logic IDLE_FILL = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    function automatic int unsigned entry_w(input int unsigned data_w,
                                            input int unsigned idx_w,
                                            input int unsigned tag_w);
        return 2 * data_w + idx_w + tag_w;
    endfunction

endpackage

// File: rtl/cnu_tree_sched_if.sv
// Request and result streams of the CNU tree scheduler.
interface cnu_tree_sched_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned data_w = 8,
    parameter int unsigned idx_w  = 8,
    parameter int unsigned D      = 5,
    parameter int unsigned TAG_W  = 2
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*data_w*D-1:0] req_data;
    logic                      res_valid;
    logic                      res_ready;
    logic [data_w-1:0]         res_min;
    logic [data_w-1:0]         res_min2;
    logic [idx_w-1:0]          res_min_idx;
    logic [TAG_W-1:0]          res_tag;

    // Requesters plus result consumer.
    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_min, res_min2, res_min_idx, res_tag
    );

    // The scheduler.
    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_min, res_min2, res_min_idx, res_tag
    );
endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after a
// rotating pointer; the pointer moves past the winner on every grant.
module rr_arb
    import cnu_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned TAG_W = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt_c,
    output logic [TAG_W-1:0] gnt_idx_c
);

    logic [TAG_W-1:0] rr_ptr;

    // Scan downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        logic [TAG_W-1:0] k;
        k         = '0;
        gnt_c     = '0;
        gnt_idx_c = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            k = TAG_W'((32'(rr_ptr) + 32'(i)) % N_REQ);
            if (en && req[k]) begin
                gnt_c     = '0;
                gnt_c[k]  = 1'b1;
                gnt_idx_c = k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|gnt_c) begin
            rr_ptr <= (gnt_idx_c == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx_c + TAG_W'(1);
        end
    end

endmodule

// File: rtl/cnu_tree_sched.sv
// Shares one min/min2 comparator tree between N_REQ requesters: round-robin
// issue, tag tracking through the tree latency, and a credit-guarded result FIFO.
module cnu_tree_sched
    import cnu_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned data_w   = 8,
    parameter int unsigned idx_w    = 8,
    parameter int unsigned D        = 5,
    parameter int unsigned TAG_W    = clog2(N_REQ),
    parameter int unsigned TREE_LAT = 1,
    parameter int unsigned FIFO_D   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cnu_tree_sched_if.slave      bus,
    output logic [data_w*D-1:0]  tree_in,
    input  logic [data_w-1:0]    tree_min,
    input  logic [data_w-1:0]    tree_min2,
    input  logic [idx_w-1:0]     tree_min_idx,
    output logic                 busy
);

    localparam int unsigned VEC_W   = data_w * D;
    localparam int unsigned ENTRY_W = entry_w(data_w, idx_w, TAG_W);
    localparam int unsigned PTR_W   = clog2(FIFO_D);
    localparam int unsigned CNT_W   = clog2(FIFO_D + 1);
    localparam int unsigned LAT_W   = clog2(TREE_LAT + 1);
    localparam int unsigned PIPE_TW = TREE_LAT * TAG_W;

    logic [N_REQ-1:0]   gnt_c;
    logic [TAG_W-1:0]   gnt_idx_c;
    logic               hs_c;
    logic               issue_ok_c;
    logic [LAT_W-1:0]   inflight_c;

    logic [TREE_LAT-1:0] pipe_vld;
    logic [PIPE_TW-1:0]  pipe_tag;

    logic [ENTRY_W-1:0] mem [FIFO_D];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_c;
    logic               pop_c;
    logic               nempty_c;
    logic               full_c;
    logic [ENTRY_W-1:0] head_c;

    // Credit covers both buffered entries and ops still inside the tree; a pop in this cycle is not counted.
    assign inflight_c = LAT_W'($countones(pipe_vld));
    assign issue_ok_c = (32'(count) + 32'(inflight_c)) < FIFO_D;

    rr_arb #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (issue_ok_c),
        .req       (bus.req_valid),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    assign bus.req_ready = gnt_c;
    assign hs_c          = |gnt_c;

    always_comb begin
        tree_in = {VEC_W{IDLE_FILL}};
        for (int unsigned r = 0; r < N_REQ; r++) begin
            if (gnt_c[r]) tree_in = bus.req_data[r*VEC_W +: VEC_W];
        end
    end

    // Tag pipe mirrors the tree latency; stage 0 is the LSB end.
    always_ff @(posedge clk) begin
        if (rst) pipe_vld <= '0;
        else     pipe_vld <= TREE_LAT'({pipe_vld, hs_c});
    end

    always_ff @(posedge clk) begin
        pipe_tag <= PIPE_TW'({pipe_tag, gnt_idx_c});
    end

    assign push_c   = pipe_vld[TREE_LAT-1];
    assign nempty_c = (count != '0);
    assign full_c   = (count == CNT_W'(FIFO_D));
    assign pop_c    = nempty_c && bus.res_ready;

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {tree_min, tree_min2, tree_min_idx,
                            pipe_tag[PIPE_TW-1 -: TAG_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= (wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (pop_c && !push_c) count <= count - CNT_W'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_c && full_c));

    // Head entry is gated so an empty FIFO presents zeros rather than stale data.
    assign head_c          = mem[rd_ptr];
    assign bus.res_valid   = nempty_c;
    assign bus.res_min     = nempty_c ? head_c[ENTRY_W-1 -: data_w]       : '0;
    assign bus.res_min2    = nempty_c ? head_c[idx_w+TAG_W +: data_w]     : '0;
    assign bus.res_min_idx = nempty_c ? head_c[TAG_W +: idx_w]            : '0;
    assign bus.res_tag     = nempty_c ? head_c[TAG_W-1:0]                 : '0;

    assign busy = nempty_c || (pipe_vld != '0);

endmodule
